// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, per-frame hit accumulation with ghost rejection,
// frame-rate debounce; accepted keys pulse key_valid one clock after frame end and shift into val_out.
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] val_out
);

  localparam int CW = (SCAN_CYCLES < 2) ? 1 : $clog2(SCAN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CYCLES);
  localparam logic [3:0]    DB       = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_e;

  logic [3:0]    sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    col_q, col_d;
  logic [1:0]    hits_q, hits_d, hits_acc;
  logic [3:0]    first_q, first_d, code_acc;
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic [15:0]   val_q, val_d;

  logic [3:0] rows_s;
  logic       sample, frame_end, accept, single, none;
  logic [1:0] col_idx;

  assign rows_s    = ~sync2_q;
  assign sample    = (cnt_q == CNT_LAST);
  assign frame_end = sample && (col_q == 4'b1000);
  assign col_out   = ~col_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign val_out   = val_q;

  always_comb begin
    col_idx = 2'd0;
    case (col_q)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    cnt_d = sample ? '0 : cnt_q + 1'b1;
    col_d = col_q;
    if (sample) begin
      case (col_q)
        4'b0001: col_d = 4'b0010;
        4'b0010: col_d = 4'b0100;
        4'b0100: col_d = 4'b1000;
        default: col_d = 4'b0001;
      endcase
    end
  end

  // Hit count saturates at 2; the current sample is folded in so frame_end sees the whole frame.
  always_comb begin
    hits_acc = hits_q;
    code_acc = first_q;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        if (rows_s[r]) begin
          if (hits_acc == 2'd0) code_acc = {2'(r), col_idx};
          if (hits_acc != 2'd2) hits_acc = hits_acc + 2'd1;
        end
      end
    end
    hits_d  = frame_end ? 2'd0 : hits_acc;
    first_d = frame_end ? 4'd0 : code_acc;
  end

  assign single = (hits_acc == 2'd1);
  assign none   = (hits_acc == 2'd0);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dcnt_d  = dcnt_q;
    accept  = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (single) begin
            cand_d  = code_acc;
            dcnt_d  = 4'd1;
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (single && code_acc == cand_q) begin
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_q + 4'd1 == DB) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else if (single) begin
            cand_d = code_acc;
            dcnt_d = 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (none) begin
            dcnt_d  = 4'd1;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (none) begin
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_q + 4'd1 == DB) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d = accept;
    code_d  = accept ? cand_q : code_q;
    val_d   = accept ? {val_q[11:0], cand_q} : val_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      cnt_q   <= '0;
      col_q   <= 4'b0001;
      hits_q  <= 2'd0;
      first_q <= 4'd0;
      state_q <= IDLE;
      cand_q  <= 4'd0;
      dcnt_q  <= 4'd0;
      valid_q <= 1'b0;
      code_q  <= 4'd0;
      val_q   <= 16'h0000;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      hits_q  <= hits_d;
      first_q <= first_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      dcnt_q  <= dcnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      val_q   <= val_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, frame-level run-length reference, pulse scoreboard.
module tb_keypad_scanner;

  localparam int SC = 3;
  localparam int DB = 3;
  localparam int FR = 4 * (SC + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] val_out;
  logic [15:0] press_mask = 16'h0000;

  int nvec = 0;
  int nmis = 0;
  int cyc;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] val;
    int          at;
  } exp_t;
  exp_t sb[$];

  bit          held;
  int          run, nrun, fidx;
  logic [3:0]  last;
  logic [15:0] mval;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .val_out   (val_out)
  );

  // A pressed key shorts its row to its column; the row reads low only while that column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: a key is accepted after DB consecutive identical single-key frames
  // and re-armed only after DB consecutive empty frames.
  task automatic model_frame(input logic [15:0] m);
    int n;
    int c;
    exp_t e;
    n = $countones(m);
    c = 0;
    for (int i = 0; i < 16; i++) if (m[i]) c = i;
    if (!held) begin
      if (n == 1) begin
        if (run > 0 && 4'(c) == last) run++;
        else begin
          run  = 1;
          last = 4'(c);
        end
        if (run == DB) begin
          mval   = {mval[11:0], 4'(c)};
          e.code = 4'(c);
          e.val  = mval;
          e.at   = FR * (fidx + 1);
          sb.push_back(e);
          held = 1'b1;
          nrun = 0;
        end
      end else begin
        run = 0;
      end
    end else begin
      if (n == 0) begin
        nrun++;
        if (nrun == DB) begin
          held = 1'b0;
          run  = 0;
        end
      end else begin
        nrun = 0;
      end
    end
  endtask

  task automatic model_reset();
    held = 1'b0;
    run  = 0;
    nrun = 0;
    fidx = 0;
    last = 4'd0;
    mval = 16'h0000;
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      press_mask = m;
      model_frame(m);
      fidx++;
      repeat (FR) @(negedge clk);
    end
  endtask

  function automatic logic [15:0] key(input int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << c;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col_out"},   32'(col_out),   32'h0000000E);
    chk({tag, "_key_valid"}, 32'(key_valid), 32'h0);
    chk({tag, "_key_code"},  32'(key_code),  32'h0);
    chk({tag, "_val_out"},   32'(val_out),   32'h0);
  endtask

  always @(negedge clk) begin
    logic [3:0] ec;
    logic [3:0] one;
    exp_t e;
    if (rst) begin
      one = 4'b0001;
      ec  = ~(one << ((cyc / (SC + 1)) % 4));
      chk("col_scan", 32'(col_out), 32'(ec));
      if (key_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_pulse", 32'(key_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("pulse_code",  32'(key_code), 32'(e.code));
          chk("pulse_val",   32'(val_out),  32'(e.val));
          chk("pulse_cycle", 32'(cyc),      32'(e.at));
        end
      end else if (sb.size() > 0 && cyc > sb[0].at) begin
        chk("missing_pulse", 32'(key_valid), 32'h1);
        sb.delete(0);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    frames(key(6), 10);
    frames(16'h0000, 4);
    chk("single_code", 32'(key_code), 32'h6);
    chk("single_val",  32'(val_out),  32'h0006);

    for (int d = 1; d <= 4; d++) begin
      frames(key(d), 4);
      frames(16'h0000, 4);
    end
    chk("entry_val_1234", 32'(val_out), 32'h1234);
    frames(key(15), 4);
    frames(16'h0000, 4);
    chk("entry_val_234F", 32'(val_out),  32'h234F);
    chk("entry_code_F",   32'(key_code), 32'hF);

    frames(key(9), 2);
    frames(16'h0000, 4);
    chk("bounce_val", 32'(val_out), 32'h234F);
    frames(key(5), 4);
    frames(16'h0000, 1);
    frames(key(5), 4);
    frames(16'h0000, 4);
    chk("rebounce_val", 32'(val_out), 32'h34F5);

    frames(key(0) | key(5), 6);
    frames(16'h0000, 2);
    chk("ghost_val",  32'(val_out),  32'h34F5);
    chk("ghost_code", 32'(key_code), 32'h5);

    for (int i = 0; i < 60; ) begin
      int kind;
      int len;
      int a;
      int b;
      logic [15:0] m;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      if (kind < 3)      m = 16'h0000;
      else if (kind < 9) m = key(a);
      else               m = key(a) | key(b);
      frames(m, len);
      i += len;
    end
    frames(16'h0000, 4);
    chk("random_val", 32'(val_out), 32'(mval));

    frames(key(7), 2);
    repeat (5) @(negedge clk);
    chk("pending_at_reset", 32'(sb.size()), 32'h0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    frames(key(7), 6);
    frames(16'h0000, 4);
    chk("midreset_code", 32'(key_code), 32'h7);
    chk("midreset_val",  32'(val_out),  32'h0007);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
